// File: rtl/fix2flt_sched_pkg.sv
// Shared types for the fix-to-float request scheduler (see FIX2FLT_SCHED_FIXED_PRIO_EN in the arbiter).
package fix2flt_pkg;

  localparam int DEF_DW   = 32;
  localparam int TAG_ID_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic                valid;
    logic [TAG_ID_W-1:0] id;
  } tag_t;

endpackage

// File: rtl/fix2flt_sched_rr_arbiter.sv
// One-hot requester arbiter, round-robin by default.
// Defining FIX2FLT_SCHED_FIXED_PRIO_EN switches to fixed lowest-index priority.
module rr_arbiter
  import fix2flt_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             adv_i,
  output logic [N_REQ-1:0] gnt_o
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [IW-1:0] idx_s;
  logic          found_s;
  logic          take_s;

`ifdef FIX2FLT_SCHED_FIXED_PRIO_EN
  logic unused_s;
  assign unused_s = ^{clk, rst_n, adv_i};

  // Fixed priority: scan upward from index 0, first valid request wins.
  always_comb begin
    gnt_o   = {N_REQ{1'b0}};
    found_s = 1'b0;
    take_s  = 1'b0;
    idx_s   = {IW{1'b0}};
    for (int k = 0; k < N_REQ; k++) begin
      idx_s        = IW'(k);
      take_s       = ~found_s & req_i[idx_s];
      gnt_o[idx_s] = take_s;
      found_s      = found_s | take_s;
    end
  end
`else
  logic [IW-1:0] last_q;
  logic [IW-1:0] last_d;

  // Round-robin: scan starts one past the last granted index and wraps.
  always_comb begin
    gnt_o   = {N_REQ{1'b0}};
    last_d  = last_q;
    found_s = 1'b0;
    take_s  = 1'b0;
    idx_s   = {IW{1'b0}};
    for (int k = 1; k <= N_REQ; k++) begin
      idx_s        = IW'((int'(last_q) + k) % N_REQ);
      take_s       = ~found_s & req_i[idx_s];
      gnt_o[idx_s] = take_s;
      found_s      = found_s | take_s;
      last_d       = take_s ? idx_s : last_d;
    end
  end

  // Pointer moves only when a grant is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= IW'(N_REQ - 1);
    end else if (adv_i) begin
      last_q <= last_d;
    end else begin
      last_q <= last_q;
    end
  end
`endif

endmodule

// File: rtl/fix2flt_sched.sv
// Schedules N_REQ requesters onto one fixed-latency fix-to-float core and routes results back.
// Arbitration policy is selected by FIX2FLT_SCHED_FIXED_PRIO_EN inside rr_arbiter.
module fix2flt_sched
  import fix2flt_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int CORE_LAT = 6,
  parameter int DW       = DEF_DW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [DW-1:0]       core_a,
  output logic                core_valid,
  input  logic [DW-1:0]       core_res,
  output logic [N_REQ-1:0]    rsp_valid,
  output logic [DW-1:0]       rsp_data,
  output logic                idle
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(CORE_LAT + 3);

  state_e           state_q;
  state_e           state_d;
  tag_t             tag_q [CORE_LAT+1];
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    cnt_d;
  logic [DW-1:0]    core_a_q;
  logic             core_valid_q;
  logic [N_REQ-1:0] rsp_valid_q;
  logic [DW-1:0]    rsp_data_q;
  logic             idle_q;

  logic [N_REQ-1:0] gnt_s;
  logic             xfer_s;
  logic             rsp_any_s;
  logic [IW-1:0]    gidx_s;
  logic [DW-1:0]    gdata_s;

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .req_i (req_valid),
    .adv_i (xfer_s),
    .gnt_o (gnt_s)
  );

  assign req_ready  = (state_q == ST_RUN) ? gnt_s : {N_REQ{1'b0}};
  assign xfer_s     = |(req_valid & req_ready);
  assign rsp_any_s  = |rsp_valid_q;

  assign core_a     = core_a_q;
  assign core_valid = core_valid_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign idle       = idle_q;

  // Encode the one-hot grant into an index and select that requester's operand.
  always_comb begin
    gidx_s  = {IW{1'b0}};
    gdata_s = {DW{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      gidx_s  = req_ready[i] ? IW'(i) : gidx_s;
      gdata_s = req_ready[i] ? req_data[i*DW +: DW] : gdata_s;
    end
  end

  // Control FSM; en has no effect while draining.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  state_d = en ? ST_RUN : ST_IDLE;
      ST_RUN:   state_d = en ? ST_RUN : ST_DRAIN;
      ST_DRAIN: state_d = (cnt_q == {CW{1'b0}}) ? ST_IDLE : ST_DRAIN;
      default:  state_d = ST_IDLE;
    endcase
  end

  // In-flight count: accepts minus delivered results.
  always_comb begin
    cnt_d = cnt_q;
    if (xfer_s && !rsp_any_s) begin
      cnt_d = cnt_q + CW'(1);
    end else if (!xfer_s && rsp_any_s) begin
      cnt_d = cnt_q - CW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State, core issue, tag pipeline aligned with core_res, and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= {CW{1'b0}};
      core_a_q     <= {DW{1'b0}};
      core_valid_q <= 1'b0;
      rsp_valid_q  <= {N_REQ{1'b0}};
      rsp_data_q   <= {DW{1'b0}};
      idle_q       <= 1'b1;
      for (int k = 0; k <= CORE_LAT; k++) begin
        tag_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      idle_q       <= (state_d == ST_IDLE) && (cnt_d == {CW{1'b0}});
      core_valid_q <= xfer_s;
      if (xfer_s) begin
        core_a_q <= gdata_s;
      end
      tag_q[0] <= {xfer_s, TAG_ID_W'(gidx_s)};
      for (int k = 1; k <= CORE_LAT; k++) begin
        tag_q[k] <= tag_q[k-1];
      end
      // The last tag stage sits in the same cycle as its core_res.
      rsp_valid_q <= tag_q[CORE_LAT].valid ? (N_REQ'(1) << tag_q[CORE_LAT].id)
                                           : {N_REQ{1'b0}};
      if (tag_q[CORE_LAT].valid) begin
        rsp_data_q <= core_res;
      end
    end
  end

endmodule
